// File: rtl/slc3_pkg.sv
// Shared encodings for the SLC-3 datapath: mux selects, ALU ops,
// memory FSM states and the R7 link-register index.
package slc3_pkg;

  typedef enum logic [1:0] {
    PCMUX_INC  = 2'b00,
    PCMUX_BUS  = 2'b01,
    PCMUX_ADDR = 2'b10,
    PCMUX_HOLD = 2'b11
  } pcmux_e;

  typedef enum logic [1:0] {
    ADDR2_ZERO  = 2'b00,
    ADDR2_OFF6  = 2'b01,
    ADDR2_OFF9  = 2'b10,
    ADDR2_OFF11 = 2'b11
  } addr2mux_e;

  typedef enum logic [1:0] {
    ALUK_ADD  = 2'b00,
    ALUK_AND  = 2'b01,
    ALUK_NOT  = 2'b10,
    ALUK_PASS = 2'b11
  } aluk_e;

  typedef enum logic {
    MEM_IDLE = 1'b0,
    MEM_WAIT = 1'b1
  } mem_state_e;

  localparam logic [2:0] R7_IDX = 3'd7;

endpackage

// File: rtl/slc3_reg_file.sv
// Eight-entry register file: two combinational read ports, one write port.
// A read of the register being written returns the pre-edge value.
module slc3_reg_file #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [2:0]        dr,
  input  logic [2:0]        sr1,
  input  logic [2:0]        sr2,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] sr1_data,
  output logic [DATA_W-1:0] sr2_data
);

  logic [DATA_W-1:0] rd_arr [8];

  for (genvar gi = 0; gi < 8; gi++) begin : g_reg
    logic [DATA_W-1:0] r_q;
    logic [DATA_W-1:0] r_d;

    always_comb begin
      r_d = r_q;
      if (we && (dr == 3'(gi))) r_d = din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_q <= '0;
      else        r_q <= r_d;
    end

    assign rd_arr[gi] = r_q;
  end

  assign sr1_data = rd_arr[sr1];
  assign sr2_data = rd_arr[sr2];

endmodule

// File: rtl/slc3_datapath_p.sv
// SLC-3 datapath: gated bus, ALU, address adder, PC/MAR/MDR/IR, NZP/BEN, LED
// and a timed memory-read FSM. Define SLC3_BUS_CHECK_EN to enable bus-conflict detection.
module slc3_datapath_p #(
  parameter int                DATA_W      = 16,
  parameter int                MEM_TIMEOUT = 15,
  parameter logic [DATA_W-1:0] PC_RESET    = '0
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              LD_MAR,
  input  logic              LD_MDR,
  input  logic              LD_IR,
  input  logic              LD_BEN,
  input  logic              LD_CC,
  input  logic              LD_REG,
  input  logic              LD_PC,
  input  logic              LD_LED,
  input  logic              GatePC,
  input  logic              GateMDR,
  input  logic              GateALU,
  input  logic              GateMARMUX,
  input  logic [1:0]        PCMUX,
  input  logic [1:0]        ADDR2MUX,
  input  logic [1:0]        ALUK,
  input  logic              DRMUX,
  input  logic              SR1MUX,
  input  logic              SR2MUX,
  input  logic              ADDR1MUX,
  input  logic              MIO_EN,
  input  logic [DATA_W-1:0] MDR_In,
  input  logic              Mem_Ack,
  output logic              Mem_Req,
  output logic              Mem_Busy,
  output logic              Mem_Err,
  output logic              Bus_Err,
  output logic [DATA_W-1:0] MAR,
  output logic [DATA_W-1:0] MDR,
  output logic [DATA_W-1:0] PC,
  output logic [DATA_W-1:0] IR,
  output logic              BEN,
  output logic [9:0]        LED
);
  import slc3_pkg::*;

  localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  logic [DATA_W-1:0] pc_q, pc_d, mar_q, mar_d, mdr_q, mdr_d, ir_q, ir_d;
  logic [2:0]        nzp_q, nzp_d;
  logic              ben_q, ben_d;
  logic [9:0]        led_q, led_d;
  mem_state_e        mem_state_q, mem_state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              mem_req_q, mem_req_d, mem_err_q, mem_err_d;

  logic [DATA_W-1:0] bus, alu_out, alu_b, addr1, addr2, addr_sum;
  logic [DATA_W-1:0] sr1_data, sr2_data, sext5, sext6, sext9, sext11;
  logic [2:0]        sr1_idx, dr_idx;
  logic              bus_n, bus_z;
  logic              ir_unused;

  // Opcode bits (and any bits above 15) are decoded by the external control unit.
  assign ir_unused = ^ir_q[DATA_W-1:12];

  assign sext5  = {{(DATA_W-5){ir_q[4]}},   ir_q[4:0]};
  assign sext6  = {{(DATA_W-6){ir_q[5]}},   ir_q[5:0]};
  assign sext9  = {{(DATA_W-9){ir_q[8]}},   ir_q[8:0]};
  assign sext11 = {{(DATA_W-11){ir_q[10]}}, ir_q[10:0]};

  assign sr1_idx = SR1MUX ? ir_q[8:6] : ir_q[11:9];
  assign dr_idx  = DRMUX  ? R7_IDX    : ir_q[11:9];

  slc3_reg_file #(.DATA_W(DATA_W)) u_reg_file (
    .clk      (Clk),
    .rst_n    (Reset_n),
    .we       (LD_REG),
    .dr       (dr_idx),
    .sr1      (sr1_idx),
    .sr2      (ir_q[2:0]),
    .din      (bus),
    .sr1_data (sr1_data),
    .sr2_data (sr2_data)
  );

  assign alu_b = SR2MUX ? sext5 : sr2_data;
  assign addr1 = ADDR1MUX ? sr1_data : pc_q;
  assign addr_sum = addr1 + addr2;

  always_comb begin
    alu_out = '0;
    case (aluk_e'(ALUK))
      ALUK_ADD:  alu_out = sr1_data + alu_b;
      ALUK_AND:  alu_out = sr1_data & alu_b;
      ALUK_NOT:  alu_out = ~sr1_data;
      ALUK_PASS: alu_out = sr1_data;
    endcase
  end

  always_comb begin
    addr2 = '0;
    case (addr2mux_e'(ADDR2MUX))
      ADDR2_ZERO:  addr2 = '0;
      ADDR2_OFF6:  addr2 = sext6;
      ADDR2_OFF9:  addr2 = sext9;
      ADDR2_OFF11: addr2 = sext11;
    endcase
  end

  always_comb begin
    bus = '0;
    if (GatePC)          bus = pc_q;
    else if (GateMDR)    bus = mdr_q;
    else if (GateALU)    bus = alu_out;
    else if (GateMARMUX) bus = addr_sum;
  end

  assign bus_n = bus[DATA_W-1];
  assign bus_z = (bus == '0);

  always_comb begin
    pc_d  = pc_q;
    mar_d = LD_MAR ? bus : mar_q;
    ir_d  = LD_IR  ? bus : ir_q;
    led_d = LD_LED ? ir_q[9:0] : led_q;
    nzp_d = LD_CC  ? {bus_n, bus_z, !bus_n && !bus_z} : nzp_q;
    // BEN samples the NZP held before this edge, not nzp_d.
    ben_d = LD_BEN ? ((ir_q[11] & nzp_q[2]) | (ir_q[10] & nzp_q[1]) | (ir_q[9] & nzp_q[0]))
                   : ben_q;
    if (LD_PC) begin
      case (pcmux_e'(PCMUX))
        PCMUX_INC:  pc_d = pc_q + DATA_W'(1);
        PCMUX_BUS:  pc_d = bus;
        PCMUX_ADDR: pc_d = addr_sum;
        PCMUX_HOLD: pc_d = pc_q;
      endcase
    end
  end

  always_comb begin
    mem_state_d = mem_state_q;
    cnt_d       = cnt_q;
    mem_req_d   = 1'b0;
    mem_err_d   = mem_err_q;
    mdr_d       = mdr_q;
    if (LD_MDR && !MIO_EN) mdr_d = bus;
    case (mem_state_q)
      MEM_IDLE: begin
        if (LD_MDR && MIO_EN) begin
          mem_state_d = MEM_WAIT;
          cnt_d       = '0;
          mem_req_d   = 1'b1;
        end
      end
      MEM_WAIT: begin
        // An acknowledge on the final cycle still beats the timeout.
        if (Mem_Ack) begin
          mdr_d       = MDR_In;
          mem_state_d = MEM_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          mdr_d       = '1;
          mem_err_d   = 1'b1;
          mem_state_d = MEM_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pc_q        <= PC_RESET;
      mar_q       <= '0;
      mdr_q       <= '0;
      ir_q        <= '0;
      nzp_q       <= 3'b010;
      ben_q       <= 1'b0;
      led_q       <= '0;
      mem_state_q <= MEM_IDLE;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_err_q   <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      mar_q       <= mar_d;
      mdr_q       <= mdr_d;
      ir_q        <= ir_d;
      nzp_q       <= nzp_d;
      ben_q       <= ben_d;
      led_q       <= led_d;
      mem_state_q <= mem_state_d;
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_err_q   <= mem_err_d;
    end
  end

`ifdef SLC3_BUS_CHECK_EN
  logic       bus_err_q, bus_err_d;
  logic [2:0] gate_cnt;

  always_comb begin
    gate_cnt  = 3'(GatePC) + 3'(GateMDR) + 3'(GateALU) + 3'(GateMARMUX);
    bus_err_d = bus_err_q | (gate_cnt > 3'd1);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) bus_err_q <= 1'b0;
    else          bus_err_q <= bus_err_d;
  end

  assign Bus_Err = bus_err_q;
`else
  assign Bus_Err = 1'b0;
`endif

  assign Mem_Req  = mem_req_q;
  assign Mem_Busy = (mem_state_q == MEM_WAIT);
  assign Mem_Err  = mem_err_q;
  assign MAR      = mar_q;
  assign MDR      = mdr_q;
  assign PC       = pc_q;
  assign IR       = ir_q;
  assign BEN      = ben_q;
  assign LED      = led_q;

endmodule

// File: tb/tb_slc3_datapath_p.sv
// Directed self-checking bench for slc3_datapath_p (default parameters).
module tb_slc3_datapath_p;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED;
  logic        GatePC, GateMDR, GateALU, GateMARMUX;
  logic [1:0]  PCMUX, ADDR2MUX, ALUK;
  logic        DRMUX, SR1MUX, SR2MUX, ADDR1MUX, MIO_EN;
  logic [15:0] MDR_In;
  logic        Mem_Ack;
  logic        Mem_Req, Mem_Busy, Mem_Err, Bus_Err;
  logic [15:0] MAR, MDR, PC, IR;
  logic        BEN;
  logic [9:0]  LED;

  int checks = 0;
  int failures = 0;
  int busy_n, req_n;

  always #5 Clk = ~Clk;

  slc3_datapath_p dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .LD_IR(LD_IR), .LD_BEN(LD_BEN),
    .LD_CC(LD_CC), .LD_REG(LD_REG), .LD_PC(LD_PC), .LD_LED(LD_LED),
    .GatePC(GatePC), .GateMDR(GateMDR), .GateALU(GateALU), .GateMARMUX(GateMARMUX),
    .PCMUX(PCMUX), .ADDR2MUX(ADDR2MUX), .ALUK(ALUK),
    .DRMUX(DRMUX), .SR1MUX(SR1MUX), .SR2MUX(SR2MUX), .ADDR1MUX(ADDR1MUX), .MIO_EN(MIO_EN),
    .MDR_In(MDR_In), .Mem_Ack(Mem_Ack),
    .Mem_Req(Mem_Req), .Mem_Busy(Mem_Busy), .Mem_Err(Mem_Err), .Bus_Err(Bus_Err),
    .MAR(MAR), .MDR(MDR), .PC(PC), .IR(IR), .BEN(BEN), .LED(LED)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("check %-14s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic clear_ctrl();
    {LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED} = '0;
    {GatePC, GateMDR, GateALU, GateMARMUX} = '0;
    PCMUX = 2'b00; ADDR2MUX = 2'b00; ALUK = 2'b00;
    {DRMUX, SR1MUX, SR2MUX, ADDR1MUX, MIO_EN} = '0;
    Mem_Ack = 1'b0;
  endtask

  // Issue a read; acknowledge during WAIT cycle ack_at (0-based), -1 for never.
  task automatic mem_read(input logic [15:0] data, input int ack_at,
                          output int busy_cnt, output int req_cnt);
    MDR_In = data; LD_MDR = 1'b1; MIO_EN = 1'b1;
    step();
    LD_MDR = 1'b0; MIO_EN = 1'b0;
    busy_cnt = 0; req_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (!Mem_Busy) break;
      busy_cnt++;
      if (Mem_Req) req_cnt++;
      Mem_Ack = (i == ack_at);
      step();
      Mem_Ack = 1'b0;
    end
  endtask

  task automatic load_ir(input logic [15:0] val);
    int b, r;
    mem_read(val, 0, b, r);
    GateMDR = 1'b1; LD_IR = 1'b1;
    step();
    clear_ctrl();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_ctrl();
    MDR_In = '0;
    Reset_n = 1'b0;
    #12;
    chk("rst_pc", PC, 16'h0000);
    chk("rst_mar", MAR, 16'h0000);
    chk("rst_mdr", MDR, 16'h0000);
    chk("rst_ir", IR, 16'h0000);
    chk("rst_ben", BEN, 1'b0);
    chk("rst_led", LED, 10'h000);
    chk("rst_req", Mem_Req, 1'b0);
    chk("rst_busy", Mem_Busy, 1'b0);
    chk("rst_err", Mem_Err, 1'b0);
    chk("rst_buserr", Bus_Err, 1'b0);
    @(negedge Clk);
    Reset_n = 1'b1;
    step();

    // PC increments
    LD_PC = 1'b1; PCMUX = 2'b00;
    repeat (3) step();
    clear_ctrl();
    chk("pc_inc3", PC, 16'h0003);

    // Read acknowledged in the third WAIT cycle
    mem_read(16'h1234, 2, busy_n, req_n);
    chk("rd_busy", busy_n, 3);
    chk("rd_req", req_n, 1);
    chk("rd_mdr", MDR, 16'h1234);
    chk("rd_err", Mem_Err, 1'b0);

    MDR_In = 16'h5555; Mem_Ack = 1'b1;
    step();
    Mem_Ack = 1'b0;
    chk("idle_ack_mdr", MDR, 16'h1234);
    chk("idle_ack_busy", Mem_Busy, 1'b0);

    // IR = ADD R1,R1,#1 ; R1 = 0x7FFF
    load_ir(16'h1221);
    chk("ir_load", IR, 16'h1221);
    mem_read(16'h7FFF, 0, busy_n, req_n);
    GateMDR = 1'b1; LD_REG = 1'b1;
    step(); clear_ctrl();

    GateALU = 1'b1; ALUK = 2'b00; SR2MUX = 1'b1; LD_MAR = 1'b1; LD_CC = 1'b1;
    step(); clear_ctrl();
    chk("alu_add_imm", MAR, 16'h8000);

    GateALU = 1'b1; ALUK = 2'b01; SR2MUX = 1'b1; LD_MAR = 1'b1;
    step(); clear_ctrl();
    chk("alu_and_imm", MAR, 16'h0001);

    GateALU = 1'b1; ALUK = 2'b10; LD_MAR = 1'b1;
    step(); clear_ctrl();
    chk("alu_not", MAR, 16'h8000);

    GateALU = 1'b1; ALUK = 2'b00; SR2MUX = 1'b0; LD_MAR = 1'b1;
    step(); clear_ctrl();
    chk("alu_add_reg", MAR, 16'hFFFE);

    GateALU = 1'b1; ALUK = 2'b00; SR2MUX = 1'b1; LD_MAR = 1'b1; LD_REG = 1'b1;
    step(); clear_ctrl();
    chk("rf_write_old", MAR, 16'h8000);
    GateALU = 1'b1; ALUK = 2'b11; LD_MAR = 1'b1;
    step(); clear_ctrl();
    chk("rf_pass_new", MAR, 16'h8000);

    // NZP = 100 from the ADD; IR[11:9]=100
    load_ir(16'h09A5);
    LD_BEN = 1'b1; LD_LED = 1'b1;
    step(); clear_ctrl();
    chk("ben_n", BEN, 1'b1);
    chk("led_load", LED, 10'h1A5);

    LD_CC = 1'b1; LD_BEN = 1'b1;
    step(); clear_ctrl();
    chk("ben_old_nzp", BEN, 1'b1);
    LD_BEN = 1'b1;
    step(); clear_ctrl();
    chk("ben_z_miss", BEN, 1'b0);

    load_ir(16'h05FE);
    LD_BEN = 1'b1;
    step(); clear_ctrl();
    chk("ben_z_hit", BEN, 1'b1);
    chk("led_hold", LED, 10'h1A5);

    // Address adder paths
    GateMARMUX = 1'b1; ADDR2MUX = 2'b10; LD_MAR = 1'b1; LD_PC = 1'b1; PCMUX = 2'b10;
    step(); clear_ctrl();
    chk("addr_off9_mar", MAR, 16'h0001);
    chk("pc_addr", PC, 16'h0001);

    GateMARMUX = 1'b1; ADDR2MUX = 2'b11; LD_MAR = 1'b1;
    step(); clear_ctrl();
    chk("addr_off11", MAR, 16'hFDFF);

    GateMARMUX = 1'b1; ADDR1MUX = 1'b1; ADDR2MUX = 2'b01; LD_MAR = 1'b1;
    step(); clear_ctrl();
    chk("addr_sr1_off6", MAR, 16'hFFFE);

    LD_PC = 1'b1; PCMUX = 2'b10; ADDR2MUX = 2'b01;
    step(); clear_ctrl();
    chk("pc_ffff", PC, 16'hFFFF);
    LD_PC = 1'b1; PCMUX = 2'b00;
    step(); clear_ctrl();
    chk("pc_wrap", PC, 16'h0000);

    GatePC = 1'b1; GateMDR = 1'b1; LD_MAR = 1'b1;
    step(); clear_ctrl();
    chk("bus_priority", MAR, 16'h0000);
`ifdef SLC3_BUS_CHECK_EN
    chk("bus_err_set", Bus_Err, 1'b1);
    step();
    chk("bus_err_sticky", Bus_Err, 1'b1);
`else
    chk("bus_err_tied", Bus_Err, 1'b0);
`endif

    LD_PC = 1'b1; PCMUX = 2'b01; GateMDR = 1'b1;
    step(); clear_ctrl();
    chk("pc_bus", PC, 16'h05FE);
    LD_PC = 1'b1; PCMUX = 2'b11;
    step(); clear_ctrl();
    chk("pc_hold", PC, 16'h05FE);

    GateMARMUX = 1'b1; ADDR2MUX = 2'b01; LD_MDR = 1'b1; MIO_EN = 1'b0;
    step(); clear_ctrl();
    chk("mdr_from_bus", MDR, 16'h05FC);
    chk("mdr_bus_idle", Mem_Busy, 1'b0);

    // Timeout handling
    mem_read(16'hA5A5, 14, busy_n, req_n);
    chk("to_ack_busy", busy_n, 15);
    chk("to_ack_mdr", MDR, 16'hA5A5);
    chk("to_ack_err", Mem_Err, 1'b0);

    mem_read(16'h1111, -1, busy_n, req_n);
    chk("to_busy", busy_n, 15);
    chk("to_req", req_n, 1);
    chk("to_mdr", MDR, 16'hFFFF);
    chk("to_err", Mem_Err, 1'b1);

    mem_read(16'h2222, 0, busy_n, req_n);
    chk("err_sticky_mdr", MDR, 16'h2222);
    chk("err_sticky", Mem_Err, 1'b1);

    // Reset during WAIT aborts the read
    MDR_In = 16'hBEEF; LD_MDR = 1'b1; MIO_EN = 1'b1;
    step(); clear_ctrl();
    step();
    chk("mid_wait_busy", Mem_Busy, 1'b1);
    Reset_n = 1'b0;
    #2;
    chk("arst_busy", Mem_Busy, 1'b0);
    chk("arst_err", Mem_Err, 1'b0);
    chk("arst_mdr", MDR, 16'h0000);
    @(negedge Clk);
    Reset_n = 1'b1;
    Mem_Ack = 1'b1;
    step();
    step();
    Mem_Ack = 1'b0;
    chk("late_ack_mdr", MDR, 16'h0000);
    chk("late_ack_busy", Mem_Busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
